// File: rtl/ysyx_24100027_branch_unit.sv
// Branch resolution plus bimodal BHT predictor with registered mispredict pulse.
// Optional statistics counters enabled by `define YSYX_24100027_BRANCH_STATS_EN.
module ysyx_24100027_branch_unit #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_req,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_rsp,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [2:0]       branch,
    input  logic             less,
    input  logic             zero,
    input  logic             res_pred_taken,
    output logic             PCActr,
    output logic             PCBctr,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       r_bht [DEPTH];
    logic             r_pred_rsp;
    logic             r_pred_taken;
    logic             r_mispredict;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_cond;
    logic             w_miss;
    logic [1:0]       w_cur;
    logic [1:0]       w_nxt;
    logic             w_unused_bits;

    always_comb begin
        PCActr = 1'b0;
        PCBctr = 1'b0;
        unique case (branch)
            3'b001:  PCActr = 1'b1;
            3'b010: begin
                PCActr = 1'b1;
                PCBctr = 1'b1;
            end
            3'b100:  PCActr = zero;
            3'b101:  PCActr = ~zero;
            3'b110:  PCActr = less;
            3'b111:  PCActr = ~less;
            default: ;
        endcase
    end

    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_res_idx  = res_pc[IDX_W+1:2];
    assign w_cond     = res_valid & branch[2];
    assign w_miss     = w_cond & (PCActr != res_pred_taken);
    assign w_cur      = r_bht[w_res_idx];

    always_comb begin
        w_nxt = w_cur;
        if (PCActr && w_cur != 2'b11)
            w_nxt = w_cur + 2'b01;
        else if (!PCActr && w_cur != 2'b00)
            w_nxt = w_cur - 2'b01;
    end

    // The prediction read samples the table before this edge's training write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_bht[i] <= 2'b01;
            r_pred_rsp   <= 1'b0;
            r_pred_taken <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_pred_rsp   <= pred_req;
            r_mispredict <= w_miss;
            if (pred_req)
                r_pred_taken <= r_bht[w_pred_idx][1];
            if (w_cond)
                r_bht[w_res_idx] <= w_nxt;
        end
    end

    assign pred_rsp   = r_pred_rsp;
    assign pred_taken = r_pred_taken;
    assign mispredict = r_mispredict;

`ifdef YSYX_24100027_BRANCH_STATS_EN
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_cond)
                r_br_cnt <= r_br_cnt + 1'b1;
            if (w_miss)
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign br_cnt   = r_br_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign br_cnt   = '0;
    assign miss_cnt = '0;
`endif

    assign w_unused_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                             res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

endmodule
